dut_run_sequencer: RTL and testbench
====================================

# dut_run_sequencer

Synthesizable, parametrised run sequencer that drives a DUT's reset and staged enables and bounds the run length. It turns a fixed reset/enable/finish stimulus into a reusable block with several capabilities:
- restart on `start`, stop on `abort`
- staggered per-channel enables
- a run timeout reported through `done`

It sits between a top-level harness (or an on-chip controller) and one or more `tt_um_*` style cores.

## Interface
Parameters:
- NUM_CH, 2: number of enable channels, legal range 1..8
- RST_CYCLES, 3: cycles `dut_rst_n` is held low after start, minimum 1
- ENA_DELAY, 2: cycles from `dut_rst_n` release to `ena[0]` rising, minimum 1
- ENA_GAP, 4: cycles between successive channel enables, minimum 1
- RUN_CYCLES, 1000: cycles from last enable to `done`; 0 means run until abort

Ports:
- clk  in  1  single clock; all outputs registered on its rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level sampled each cycle; acts only in IDLE or DONE
- abort  in  1  level sampled each cycle; has priority over start
- dut_rst_n  out  1  active-low reset to the DUT
- ena  out  NUM_CH  per-channel enables
- busy  out  1  high in RESET, WAIT, STAGGER and RUN
- done  out  1  high while in DONE

## Operation
- States: IDLE, RESET, WAIT, STAGGER, RUN, DONE. Enum encoding lives in the package.
- IDLE:
  - outputs: `dut_rst_n`=0, `ena`=0, `busy`=0, `done`=0
  - `start` → RESET
- RESET:
  - outputs: `dut_rst_n`=0, `ena`=0
  - after RST_CYCLES cycles → WAIT
- WAIT:
  - outputs: `dut_rst_n`=1
  - after ENA_DELAY cycles, set `ena[0]`
  - then → STAGGER, or → RUN if NUM_CH=1
- STAGGER:
  - every ENA_GAP cycles, set the next `ena` bit
  - enabled bits stay set
  - when `ena[NUM_CH-1]` is set → RUN
- RUN:
  - all `ena` bits high
  - count RUN_CYCLES, then → DONE
  - if RUN_CYCLES=0, stay in RUN indefinitely
- DONE:
  - outputs: `ena`=0, `dut_rst_n`=0, `done`=1
  - `start` → RESET (restart)
  - otherwise hold
- abort:
  - in any state other than IDLE → IDLE on the next edge
  - all outputs take their IDLE values
  - abort together with start: abort wins
- start while busy: ignored.
- Internal down-counter:
  - width CNT_W = $clog2(max(RST_CYCLES, ENA_DELAY, ENA_GAP, RUN_CYCLES)+1)
  - reloaded on every state or channel transition
  - never wraps: it stops at 0

## Timing
- Reset values: state=IDLE, `dut_rst_n`=0, `ena`=0, `busy`=0, `done`=0, counters 0.
- Relative to the edge E at which `start` is sampled in IDLE:
  - `busy` rises at E
  - `dut_rst_n` rises at E+RST_CYCLES
  - `ena[0]` rises at E+RST_CYCLES+ENA_DELAY
  - `ena[i]` rises at E+RST_CYCLES+ENA_DELAY+i·ENA_GAP
  - `done` rises and `busy` falls at E+RST_CYCLES+ENA_DELAY+(NUM_CH-1)·ENA_GAP+RUN_CYCLES
- Abort sampled at edge A: all outputs at IDLE values from A.
- Restart from DONE: identical timeline, with E being the sampling edge in DONE.
- `rst` asserted mid-run: all outputs go to reset values immediately (asynchronous). Operation resumes only on a fresh `start` after `rst` deasserts.

## Configuration
- Macro: SEQ_CYCLE_COUNT_EN.
- Defined:
  - adds output port `cycle_count` (out, 32 bits)
  - cleared to 0 by `rst`, abort, and entry to RESET
  - increments each cycle while `dut_rst_n`=1 and state≠DONE
  - saturates at 2^32-1
  - holds its value in DONE
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Package `seq_pkg`:
  - state enum `seq_state_t`
  - constant `SEQ_MAX_CH`=8
  - function `seq_cnt_w` computing CNT_W
- Sub-module `seq_down_counter`:
  - parametrised width
  - inputs: load, load_value
  - output: zero flag
  - saturates at 0
  - one instance, shared across phases

## Test plan
- Defaults, `start` sampled at edge 0:
  - `dut_rst_n` rises at edge 3
  - `ena[0]` at edge 5, `ena[1]` at edge 9
  - `done` at edge 1009, `busy` low from edge 1009
- Abort sampled at edge 7 (`ena[0]`=1), `start` held high the same cycle → IDLE at edge 7, all outputs 0, no restart.
- NUM_CH=1, RUN_CYCLES=0:
  - `ena[0]` at edge 5
  - `done` never rises over 5000 cycles
  - abort at edge 200 → IDLE
- Restart from DONE (defaults): `start` at edge 1015 → `dut_rst_n` low from 1015, rises at 1018, `ena[0]` at 1020.
- `rst` pulsed mid-RUN at edge 500 → all outputs 0 immediately; `start` is ignored while `rst` is held; a clean timeline follows after release.
- With SEQ_CYCLE_COUNT_EN, defaults:
  - `cycle_count` is 0 through edge 3
  - `cycle_count` equals 1006 when `done` rises
  - `cycle_count` holds 1006 in DONE

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the run sequencer:
//   seq_state_t : sequencer phase encoding
//   SEQ_MAX_CH  : largest supported number of enable channels
//   seq_cnt_w() : width of the phase down-counter. It must hold the largest
//                 programmed phase length.
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_WAIT    = 3'd2,
    S_STAGGER = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

  localparam int SEQ_MAX_CH = 8;

  // Returns $clog2(max(a, b, c, d) + 1). The result is never less than 1.
  function automatic int seq_cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// ---------------------------------------------------------------------------
// seq_down_counter
// Loadable down-counter that stops at zero. One instance times every
// sequencer phase.
// Ports:
//   clk          : clock
//   rst          : asynchronous active-high reset (clears the count)
//   i_load       : load i_load_value this cycle (has priority over counting)
//   i_load_value : value to load
//   o_zero       : count is zero
// ---------------------------------------------------------------------------
module seq_down_counter
  import seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments only.
  // Mixing in blocking assignments creates simulation races between flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dut_run_sequencer.sv
// ---------------------------------------------------------------------------
// dut_run_sequencer
// Drives a DUT's active-low reset and staggered per-channel enables, and
// bounds the run length. Phases: IDLE -> RESET -> WAIT -> STAGGER -> RUN ->
// DONE. `start` restarts from IDLE or DONE. `abort` returns to IDLE and has
// priority over `start`.
// Ports:
//   clk         : clock; all outputs are registered
//   rst         : asynchronous active-high reset
//   start       : begin a run (acts only in IDLE or DONE)
//   abort       : stop and return to IDLE
//   dut_rst_n   : active-low reset to the DUT
//   ena         : per-channel enables, raised one at a time
//   busy        : high in RESET, WAIT, STAGGER and RUN
//   done        : high while in DONE
//   cycle_count : (only with SEQ_CYCLE_COUNT_EN) number of cycles the DUT
//                 has been out of reset in the current run
// Optional feature macro: SEQ_CYCLE_COUNT_EN
// ---------------------------------------------------------------------------
module dut_run_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int RST_CYCLES = 3,
  parameter int ENA_DELAY  = 2,
  parameter int ENA_GAP    = 4,
  parameter int RUN_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              dut_rst_n,
  output logic [NUM_CH-1:0] ena,
  output logic              busy,
  output logic              done
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int CNT_W = seq_cnt_w(RST_CYCLES, ENA_DELAY, ENA_GAP, RUN_CYCLES);

  // A phase of N cycles loads N-1. The transition fires on the edge where
  // the counter is already zero.
  localparam logic [CNT_W-1:0] LD_RST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_DLY = CNT_W'(ENA_DELAY - 1);
  localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(ENA_GAP - 1);
  localparam logic [CNT_W-1:0] LD_RUN = CNT_W'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

  seq_state_t        r_state;
  logic              r_dut_rst_n;
  logic [NUM_CH-1:0] r_ena;
  logic              r_busy;
  logic              r_done;

  logic              w_zero;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_value;
  logic [NUM_CH-1:0] w_ena_next;

  seq_down_counter #(.W(CNT_W)) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .o_zero       (w_zero)
  );

  // Counter reload decisions. These mirror the transitions in the FSM below.
  // Enables fill from bit 0 upward, so the next pattern is a shift-in of 1.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_load       = 1'b0;
    w_load_value = '0;
    w_ena_next   = (r_ena << 1) | NUM_CH'(1);
    if (abort) begin
      w_load = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_load       = 1'b1;
            w_load_value = LD_RST;
          end
        end
        S_RESET: begin
          if (w_zero) begin
            w_load       = 1'b1;
            w_load_value = LD_DLY;
          end
        end
        S_WAIT: begin
          if (w_zero) begin
            w_load       = 1'b1;
            w_load_value = (NUM_CH == 1) ? LD_RUN : LD_GAP;
          end
        end
        S_STAGGER: begin
          if (w_zero) begin
            w_load       = 1'b1;
            w_load_value = w_ena_next[NUM_CH-1] ? LD_RUN : LD_GAP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dut_rst_n <= 1'b0;
      r_ena       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_dut_rst_n <= 1'b0;
      r_ena       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RESET;
            r_dut_rst_n <= 1'b0;
            r_ena       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_RESET: begin
          if (w_zero) begin
            r_state     <= S_WAIT;
            r_dut_rst_n <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_zero) begin
            r_ena   <= NUM_CH'(1);
            r_state <= (NUM_CH == 1) ? S_RUN : S_STAGGER;
          end
        end
        S_STAGGER: begin
          if (w_zero) begin
            r_ena <= w_ena_next;
            if (w_ena_next[NUM_CH-1]) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // A zero run length keeps the sequencer in RUN until abort.
          if (RUN_CYCLES != 0 && w_zero) begin
            r_state     <= S_DONE;
            r_dut_rst_n <= 1'b0;
            r_ena       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_rst_n = r_dut_rst_n;
  assign ena       = r_ena;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  // Counts cycles while the DUT is out of reset. The count saturates and is
  // frozen in DONE. A new run starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_count <= '0;
    end else if (abort || ((r_state == S_IDLE || r_state == S_DONE) && start)) begin
      r_cycle_count <= '0;
    end else if (r_dut_rst_n && r_state != S_DONE && r_cycle_count != '1) begin
      r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_dut_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dut_run_sequencer
// Two sequencer instances:
//   dut0 : default parameters
//   dut1 : NUM_CH=1, RUN_CYCLES=0
// A timeline model computes each expected output from the start edge E.
// Literal checks at chosen edges pin that model.
// Define SEQ_CYCLE_COUNT_EN to also cover cycle_count.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dut_run_sequencer;

  localparam int P_RST = 3;
  localparam int P_DLY = 2;
  localparam int P_GAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, abort0, start1, abort1;
  logic       rstn0, busy0, done0;
  logic [1:0] ena0;
  logic       rstn1, busy1, done1;
  logic [0:0] ena1;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] cc0, cc1;
`endif

  dut_run_sequencer dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .abort     (abort0),
    .dut_rst_n (rstn0),
    .ena       (ena0),
    .busy      (busy0),
    .done      (done0)
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count (cc0)
`endif
  );

  dut_run_sequencer #(.NUM_CH(1), .RUN_CYCLES(0)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .abort     (abort1),
    .dut_rst_n (rstn1),
    .ena       (ena1),
    .busy      (busy1),
    .done      (done1)
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count (cc1)
`endif
  );

  // ---------------- model ----------------
  typedef struct packed {
    logic        rst_n;
    logic [7:0]  ena;
    logic        busy;
    logic        done;
    logic [31:0] cc;
  } exp_t;

  int p_nch [2] = '{2, 1};
  int p_run [2] = '{1000, 0};
  bit m_run [2] = '{1'b0, 1'b0};
  int m_e   [2] = '{0, 0};

  int cyc   = -1;
  int n_cmp = 0;
  int n_err = 0;
  bit track1 = 1'b0;
  bit seen_done1 = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int t_done(input int id);
    return P_RST + P_DLY + (p_nch[id] - 1) * P_GAP + p_run[id];
  endfunction

  function automatic bit in_done(input int id, input int t);
    return (p_run[id] != 0) && (t >= t_done(id));
  endfunction

  function automatic exp_t model_out(input int id, input int n);
    exp_t x;
    int   t;
    x = '0;
    if (!m_run[id]) return x;
    t = n - m_e[id];
    if (in_done(id, t)) begin
      x.done = 1'b1;
      x.cc   = 32'(t_done(id) - P_RST);
      return x;
    end
    x.busy  = 1'b1;
    x.rst_n = (t >= P_RST);
    for (int i = 0; i < p_nch[id]; i++)
      if (t >= P_RST + P_DLY + i * P_GAP) x.ena[i] = 1'b1;
    x.cc = (t > P_RST) ? 32'(t - P_RST) : 32'd0;
    return x;
  endfunction

  task automatic step(input int id, input logic s, input logic a);
    if (rst || a) m_run[id] = 1'b0;
    else if (s && (!m_run[id] || in_done(id, cyc - 1 - m_e[id]))) begin
      m_run[id] = 1'b1;
      m_e[id]   = cyc;
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    step(0, start0, abort0);
    step(1, start1, abort1);
  end

  // Compare process: every output of both instances on every falling edge.
  always @(negedge clk) begin
    exp_t x0, x1;
    if (rst) begin
      m_run[0] = 1'b0;
      m_run[1] = 1'b0;
    end
    x0 = model_out(0, cyc);
    x1 = model_out(1, cyc);
    check("dut0 {rst_n,ena,busy,done}", {rstn0, 6'd0, ena0, busy0, done0},
          {x0.rst_n, x0.ena, x0.busy, x0.done});
    check("dut1 {rst_n,ena,busy,done}", {rstn1, 7'd0, ena1, busy1, done1},
          {x1.rst_n, x1.ena, x1.busy, x1.done});
`ifdef SEQ_CYCLE_COUNT_EN
    check("dut0 cycle_count", cc0, x0.cc);
    check("dut1 cycle_count", cc1, x1.cc);
`endif
    if (track1 && done1) seen_done1 = 1'b1;
  end

  // Advance to the low phase after posedge number n.
  task automatic wait_to(input int n);
    do begin
      @(negedge clk);
      #1;
    end while (cyc < n);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int e0, e2, e3, e4, e5, e6;
    rst = 1'b1; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    wait_to(2);
    check("reset dut_rst_n", rstn0, 0);
    check("reset ena", ena0, 0);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    rst = 1'b0;

    // Default timeline from start edge e0.
    wait_to(4);
    start0 = 1'b1; e0 = cyc + 1;
    wait_to(e0); start0 = 1'b0;
    check("busy at E", busy0, 1);
    wait_to(e0 + 2);  check("dut_rst_n at E+2", rstn0, 0);
    wait_to(e0 + 3);  check("dut_rst_n at E+3", rstn0, 1);
`ifdef SEQ_CYCLE_COUNT_EN
    check("cycle_count at E+3", cc0, 0);
`endif
    wait_to(e0 + 4);  check("ena at E+4", ena0, 0);
    wait_to(e0 + 5);  check("ena at E+5", ena0, 1);
    wait_to(e0 + 8);  check("ena at E+8", ena0, 1);
    wait_to(e0 + 9);  check("ena at E+9", ena0, 3);
    wait_to(e0 + 1008);
    check("done at E+1008", done0, 0);
    check("busy at E+1008", busy0, 1);
    wait_to(e0 + 1009);
    check("done at E+1009", done0, 1);
    check("busy at E+1009", busy0, 0);
    check("ena at E+1009", ena0, 0);
`ifdef SEQ_CYCLE_COUNT_EN
    check("cycle_count at done", cc0, 1006);
`endif
    wait_to(e0 + 1012);
    check("done held", done0, 1);
`ifdef SEQ_CYCLE_COUNT_EN
    check("cycle_count held", cc0, 1006);
`endif

    // Restart from DONE.
    wait_to(e0 + 1014);
    start0 = 1'b1; e2 = e0 + 1015;
    wait_to(e2); start0 = 1'b0;
    check("restart busy", busy0, 1);
    check("restart done", done0, 0);
    check("restart dut_rst_n low", rstn0, 0);
    wait_to(e2 + 3); check("restart dut_rst_n at +3", rstn0, 1);
    wait_to(e2 + 5); check("restart ena at +5", ena0, 1);

    // Abort together with start at +7; no restart.
    wait_to(e2 + 6);
    abort0 = 1'b1; start0 = 1'b1;
    wait_to(e2 + 7);
    abort0 = 1'b0; start0 = 1'b0;
    check("abort outputs", {rstn0, ena0, busy0, done0}, 0);
    wait_to(e2 + 9);
    check("no restart after abort", busy0, 0);

    // Asynchronous reset mid-RUN.
    wait_to(e2 + 11);
    start0 = 1'b1; e3 = e2 + 12;
    wait_to(e3); start0 = 1'b0;
    wait_to(e3 + 500);
    check("ena before rst", ena0, 3);
    rst = 1'b1; start0 = 1'b1;
    #1;
    check("async rst outputs", {rstn0, ena0, busy0, done0}, 0);
    wait_to(e3 + 503);
    check("start ignored in rst", busy0, 0);
    start0 = 1'b0; rst = 1'b0;
    wait_to(e3 + 505);
    check("idle after rst", busy0, 0);
    start0 = 1'b1; e4 = cyc + 1;
    wait_to(e4); start0 = 1'b0;
    wait_to(e4 + 3);    check("post-rst dut_rst_n", rstn0, 1);
    wait_to(e4 + 9);    check("post-rst ena", ena0, 3);
    wait_to(e4 + 1009); check("post-rst done", done0, 1);

    // NUM_CH=1, RUN_CYCLES=0.
    start1 = 1'b1; e5 = cyc + 1;
    wait_to(e5); start1 = 1'b0;
    wait_to(e5 + 4); check("ch1 ena at +4", ena1, 0);
    wait_to(e5 + 5); check("ch1 ena at +5", ena1, 1);
    wait_to(e5 + 199);
    abort1 = 1'b1;
    wait_to(e5 + 200);
    abort1 = 1'b0;
    check("ch1 abort outputs", {rstn1, ena1, busy1, done1}, 0);
    start1 = 1'b1; e6 = cyc + 1;
    wait_to(e6); start1 = 1'b0;
    seen_done1 = 1'b0; track1 = 1'b1;
    wait_to(e6 + 5000);
    track1 = 1'b0;
    check("ch1 done never rose", seen_done1, 0);
    check("ch1 still busy", busy1, 1);
    abort1 = 1'b1;
    wait_to(cyc + 1);
    abort1 = 1'b0;
    check("ch1 idle after abort", busy1, 0);

    wait_to(cyc + 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
